// File: rtl/cache_flush_seq.sv
// cache_flush_seq -- whole-cache flush sequencer.
//
// Visits every (set, way) pair in order. For each pair it reads the set,
// checks the valid and dirty bits, writes back a dirty valid line, and then
// clears the line's dirty bit. Completion is signalled with a single-cycle
// pulse. All outputs are Moore-decoded from the state and the registered
// set and way counters.
//
// Optional feature: define CACHE_FLUSH_INVALIDATE_EN to invalidate every
// valid line as it is visited. A clean valid line then goes straight to
// CLEAN, and CLEAN asserts ClearValid together with ClearDirty. With the
// macro undefined, ClearValid is tied to 0.
//
// Ports:
//   clk, reset  : clock; asynchronous active-high reset
//   FlushReq    : start a flush (sampled only in IDLE)
//   ValidWay    : valid bits of set FlushSet, one cycle after FlushSet is driven
//   DirtyWay    : dirty bits of set FlushSet, same timing as ValidWay
//   WBAck       : writeback accepted (only looked at in WB)
//   FlushSet    : set index driven to the tag/data arrays
//   FlushWay    : one-hot way under service (0 while idle)
//   WBReq       : writeback request for (FlushSet, FlushWay)
//   ClearDirty  : clear dirty bit at (FlushSet, FlushWay)
//   ClearValid  : clear valid bit at (FlushSet, FlushWay)
//   Busy        : flush in progress
//   FlushDone   : one-cycle completion pulse
module cache_flush_seq #(
  parameter int NUMWAYS  = 4,
  parameter int NUMLINES = 128,
  parameter int SETLEN   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushReq,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic               WBAck,
  output logic [SETLEN-1:0]  FlushSet,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               WBReq,
  output logic               ClearDirty,
  output logic               ClearValid,
  output logic               Busy,
  output logic               FlushDone
);

  localparam int WAYLEN = $clog2(NUMWAYS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WB,
    S_CLEAN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [SETLEN-1:0] set_q, set_d;
  logic [WAYLEN-1:0] way_q, way_d;
  logic              last_line;
  logic              line_valid, line_dirty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      set_q <= '0;
      way_q <= '0;
    end else begin
      state <= state_next;
      set_q <= set_d;
      way_q <= way_d;
    end
  end

  assign last_line  = (set_q == SETLEN'(NUMLINES - 1)) && (way_q == WAYLEN'(NUMWAYS - 1));
  assign line_valid = ValidWay[way_q];
  assign line_dirty = DirtyWay[way_q];

  always_comb begin
    state_next = state;
    set_d      = set_q;
    way_d      = way_q;
    unique case (state)
      S_IDLE: begin
        if (FlushReq) begin
          set_d      = '0;
          way_d      = '0;
          state_next = S_READ;
        end
      end
      S_READ:  state_next = S_CHECK;
      S_CHECK: begin
        if (line_valid && line_dirty) begin
          state_next = S_WB;
        end else begin
`ifdef CACHE_FLUSH_INVALIDATE_EN
          state_next = line_valid ? S_CLEAN : S_NEXT;
`else
          state_next = S_NEXT;
`endif
        end
      end
      S_WB: begin
        if (WBAck) state_next = S_CLEAN;
      end
      S_CLEAN: state_next = S_NEXT;
      S_NEXT: begin
        // The counters always advance. On the last line both of them wrap
        // to 0, so the sequencer goes back to IDLE with zeroed counters.
        way_d = way_q + WAYLEN'(1);
        if (way_q == WAYLEN'(NUMWAYS - 1)) set_d = set_q + SETLEN'(1);
        state_next = last_line ? S_DONE : S_READ;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy       = (state != S_IDLE);
    FlushSet   = set_q;
    FlushWay   = Busy ? (NUMWAYS'(1) << way_q) : '0;
    WBReq      = (state == S_WB);
    ClearDirty = (state == S_CLEAN);
`ifdef CACHE_FLUSH_INVALIDATE_EN
    ClearValid = (state == S_CLEAN);
`else
    ClearValid = 1'b0;
`endif
    FlushDone  = (state == S_DONE);
  end

endmodule
